// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with 2-entry skid buffer, stall and flush; optional perf counters via `PIPE_STAGE_PERF_EN`
module pipe_stage #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit CLEAR_ON_FLUSH = 1'b1
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    input  logic             stall,
    input  logic             flush,
    output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] bp_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t state, state_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic in_fire, out_fire;

    assign in_ready  = (state != SKID) && !stall;
    assign out_valid = (state != EMPTY);
    assign data_out  = main_q;
    assign occupancy = (state == SKID) ? 2'd2 : (state == FULL) ? 2'd1 : 2'd0;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready && !stall;

    // Next state and payload moves; flush overrides every handshake outcome
    always_comb begin
        state_d = state;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = CLEAR_ON_FLUSH ? RESET_VAL : main_q;
            skid_d  = CLEAR_ON_FLUSH ? RESET_VAL : skid_q;
        end else begin
            case (state)
                EMPTY: begin
                    state_d = in_fire ? FULL : EMPTY;
                    main_d  = in_fire ? data_in : main_q;
                end
                FULL: begin
                    state_d = (in_fire && !out_fire) ? SKID : (!in_fire && out_fire) ? EMPTY : FULL;
                    main_d  = (in_fire && out_fire) ? data_in : main_q;
                    skid_d  = (in_fire && !out_fire) ? data_in : skid_q;
                end
                SKID: begin
                    state_d = out_fire ? FULL : SKID;
                    main_d  = out_fire ? skid_q : main_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and payload registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else begin
            state  <= state_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating counters for blocked-output cycles and flushes that kill a payload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bp_cnt    <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_fire && bp_cnt != '1) bp_cnt <= bp_cnt + CNT_W'(1);
            if (flush && out_valid && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: randomized and directed checks of pipe_stage against a queue-based reference model
module tb_pipe_stage;
    localparam logic [31:0] RESET_VAL = 32'h0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] data_in = '0;
    logic in_ready, out_valid;
    logic [31:0] data_out;
    logic [1:0] occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [3:0] bp_cnt, flush_cnt;
`endif

    int total = 0;
    int bad = 0;
    logic [31:0] q[$];
    logic [31:0] last = RESET_VAL;

    pipe_stage #(
        .WIDTH(32),
        .RESET_VAL(RESET_VAL),
        .CLEAR_ON_FLUSH(1'b1)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .CNT_W(4)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_in(data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out(data_out),
        .stall(stall),
        .flush(flush),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .bp_cnt(bp_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Expected {in_ready, out_valid, occupancy, data_out} from the queue model
    function automatic logic [35:0] expv();
        return {(q.size() < 2) && !stall, q.size() != 0, 2'(q.size()), (q.size() != 0) ? q[0] : last};
    endfunction

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic st, input logic fl);
        @(negedge clk);
        in_valid = iv; data_in = d; out_ready = ordy; stall = st; flush = fl;
        #1;
    endtask

    task automatic advance();
        logic inf, outf;
        inf  = in_valid && (q.size() < 2) && !stall;
        outf = (q.size() != 0) && out_ready && !stall;
        @(posedge clk);
        if (flush) begin
            q.delete();
            last = RESET_VAL;
        end else begin
            if (outf) last = q.pop_front();
            if (inf) q.push_back(data_in);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        drive(0, 0, 0, 0, 0);
        total++;
        if ({in_ready, out_valid, occupancy, data_out} !== {1'b1, 1'b0, 2'd0, RESET_VAL}) begin
            bad++;
            $display("FAIL reset: got %h want %h", {in_ready, out_valid, occupancy, data_out}, {1'b1, 1'b0, 2'd0, RESET_VAL});
        end
        reset = 1'b1;
        q.delete();
        last = RESET_VAL;
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 9; i++) begin
            drive(i <= 8, 32'(i), 1, 0, 0);
            total++;
            if ({in_ready, out_valid, occupancy, data_out} !== expv()) begin
                bad++;
                $display("FAIL stream[%0d]: got %h want %h", i, {in_ready, out_valid, occupancy, data_out}, expv());
            end
            if (i > 1) begin
                total++;
                if ({in_ready, occupancy, data_out} !== {1'b1, 2'd1, 32'(i - 1)}) begin
                    bad++;
                    $display("FAIL stream_seq[%0d]: got rdy=%0b occ=%0d data=%h want rdy=1 occ=1 data=%h", i, in_ready, occupancy, data_out, 32'(i - 1));
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] want[2] = '{32'hAAAA0001, 32'hAAAA0002};
        drive(1, want[0], 0, 0, 0); advance();
        drive(1, want[1], 0, 0, 0); advance();
        drive(0, 0, 0, 0, 0);
        total++;
        if ({in_ready, occupancy, data_out} !== {1'b0, 2'd2, want[0]}) begin
            bad++;
            $display("FAIL bp_full: got rdy=%0b occ=%0d data=%h want rdy=0 occ=2 data=%h", in_ready, occupancy, data_out, want[0]);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 0, 0);
            total++;
            if ({out_valid, data_out} !== {1'b1, want[i]} || {in_ready, out_valid, occupancy, data_out} !== expv()) begin
                bad++;
                $display("FAIL bp_drain[%0d]: got val=%0b data=%h want val=1 data=%h", i, out_valid, data_out, want[i]);
            end
            advance();
        end
        drive(0, 0, 1, 0, 0);
        total++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_empty: got occ=%0d val=%0b want occ=0 val=0", occupancy, out_valid);
        end
    endtask

    task automatic test_flush();
        drive(1, 32'h1111_2222, 0, 0, 0); advance();
        drive(1, 32'h3333_4444, 0, 0, 0); advance();
        drive(0, 0, 0, 0, 1);
        total++;
        if (occupancy !== 2'd2) begin
            bad++;
            $display("FAIL flush_pre: got occ=%0d want occ=2", occupancy);
        end
        advance();
        drive(0, 0, 0, 0, 0);
        total++;
        if ({out_valid, occupancy, data_out} !== {1'b0, 2'd0, RESET_VAL} || {in_ready, out_valid, occupancy, data_out} !== expv()) begin
            bad++;
            $display("FAIL flush: got val=%0b occ=%0d data=%h want val=0 occ=0 data=%h", out_valid, occupancy, data_out, RESET_VAL);
        end
    endtask

    task automatic test_stall();
        drive(1, 32'hDEADBEEF, 1, 0, 0); advance();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0BAD0BAD, 1, 1, 0);
            total++;
            if ({in_ready, out_valid, data_out} !== {1'b0, 1'b1, 32'hDEADBEEF} || {in_ready, out_valid, occupancy, data_out} !== expv()) begin
                bad++;
                $display("FAIL stall[%0d]: got rdy=%0b val=%0b data=%h want rdy=0 val=1 data=deadbeef", i, in_ready, out_valid, data_out);
            end
            advance();
        end
        drive(0, 0, 1, 0, 0); advance();
        drive(0, 0, 1, 0, 0);
        total++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_release: got occ=%0d val=%0b want occ=0 val=0", occupancy, out_valid);
        end
    endtask

    task automatic test_async_reset();
        drive(1, 32'h5555_0001, 0, 0, 0); advance();
        drive(1, 32'h5555_0002, 0, 0, 0); advance();
        drive(0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({out_valid, occupancy, data_out, in_ready} !== {1'b0, 2'd0, RESET_VAL, 1'b1}) begin
            bad++;
            $display("FAIL async_reset: got val=%0b occ=%0d data=%h rdy=%0b want val=0 occ=0 data=%h rdy=1", out_valid, occupancy, data_out, in_ready, RESET_VAL);
        end
        q.delete();
        last = RESET_VAL;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            total++;
            if ({in_ready, out_valid, occupancy, data_out} !== expv()) begin
                bad++;
                $display("FAIL random[%0d]: got %h want %h", i, {in_ready, out_valid, occupancy, data_out}, expv());
            end
            advance();
        end
        drive(0, 0, 0, 0, 1); advance();
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        reset = 1'b0;
        #1 reset = 1'b1;
        q.delete();
        last = RESET_VAL;
        drive(1, 32'h0000_0011, 0, 0, 0); advance();
        repeat (20) begin
            drive(0, 0, 0, 0, 0); advance();
        end
        drive(0, 0, 0, 0, 1);
        total++;
        if (bp_cnt !== 4'hF) begin
            bad++;
            $display("FAIL bp_cnt: got %h want f", bp_cnt);
        end
        advance();
        drive(0, 0, 0, 0, 0);
        total++;
        if (flush_cnt !== 4'd1) begin
            bad++;
            $display("FAIL flush_cnt: got %h want 1", flush_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_stall();
        test_async_reset();
        test_random();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage.md
Name: pipe_stage

Overview:
- Generic, parametrised pipeline stage register. It replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block.
- Carries a packed WIDTH-bit payload with a valid/ready handshake, a 2-entry skid buffer, stall and flush.
- Each stage boundary instantiates one copy, with its control and data fields concatenated into data_in.
- Unlike the fixed stage registers it adds backpressure, hold-under-stall and an explicit valid bit, so killed instructions become bubbles rather than zeroed fields.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- RESET_VAL, 0, payload value loaded on reset, and on flush when CLEAR_ON_FLUSH=1 (WIDTH bits, zero-extended).
- CLEAR_ON_FLUSH, 1, 1: flush also loads RESET_VAL into both payload registers; 0: flush clears valid only.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream payload valid
- in_ready  output  1  stage can accept a payload this cycle
- data_in  input  WIDTH  upstream payload
- out_valid  output  1  stage holds a valid payload
- out_ready  input  1  downstream accepts a payload this cycle
- data_out  output  WIDTH  payload presented downstream
- stall  input  1  freeze stage: no accept, no release
- flush  input  1  kill all held payloads (bubble insert)
- occupancy  output  2  number of held payloads (0..2)

Behaviour:
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready & ~stall.
- Registers: main_q and skid_q (WIDTH each); state is one of EMPTY, FULL or SKID.
- Reset (reset=0, asynchronous):
  - state=EMPTY, out_valid=0, occupancy=0.
  - main_q=skid_q=RESET_VAL, data_out=RESET_VAL.
  - in_ready=1 when stall=0.
  - Reset mid-transfer discards both entries immediately.
- Combinational outputs:
  - in_ready = (state!=SKID) & ~stall.
  - out_valid = (state!=EMPTY).
  - data_out = main_q.
  - occupancy: EMPTY=0, FULL=1, SKID=2.
- Transitions (evaluated only when flush=0):
  - EMPTY: in_fire -> FULL, main_q<=data_in.
  - FULL, in_fire & out_fire -> FULL, main_q<=data_in.
  - FULL, in_fire & ~out_fire -> SKID, skid_q<=data_in; main_q is held.
  - FULL, ~in_fire & out_fire -> EMPTY.
  - FULL, neither -> hold.
  - SKID: in_ready=0, so no in_fire is possible.
  - SKID, out_fire -> FULL, main_q<=skid_q.
  - SKID, no out_fire -> hold.
- Latency and throughput:
  - 1 cycle from in_fire to out_valid when the stage is EMPTY.
  - Sustained throughput is 1 payload/cycle with out_ready held high.
  - The payload order out equals the order in; no payload is ever duplicated or dropped except by flush.
- Flush (priority over everything except reset):
  - Next edge: state=EMPTY.
  - If CLEAR_ON_FLUSH=1, main_q and skid_q <= RESET_VAL; otherwise they are held.
  - An in_fire in the flush cycle counts as transferred upstream and is discarded.
  - An out_fire in the flush cycle still completes; downstream sees the transfer.
- Stall:
  - Forces in_ready=0 and suppresses out_fire; the state and both registers hold.
  - out_valid and data_out stay stable for the whole stall.
  - stall together with flush: flush wins.
- Payload stability: data_out may change only on an edge where out_fire=1, a flush applies, or the state moves EMPTY->FULL.
- in_ready does not depend combinationally on out_ready; the skid buffer breaks that path.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - Adds outputs bp_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0], both reset to 0.
  - bp_cnt increments on each cycle with out_valid=1 and out_fire=0, whether from backpressure or stall.
  - flush_cnt increments on each cycle with flush=1 while out_valid=1.
  - Both counters saturate at all-ones and never wrap; neither is cleared by flush.
- Undefined: the ports and logic are absent, and the behaviour is otherwise identical.

Test Plan:
- Reset is held low and then released; stream data_in=0x00000001..0x00000008 with in_valid=1 and out_ready=1. Required: data_out shows 0x1..0x8 on consecutive cycles, 1 cycle after each accept; occupancy stays at 1; in_ready stays 1.
- Backpressure: load 0xAAAA0001 and 0xAAAA0002 with out_ready=0. Required: occupancy=2 and in_ready=0. Then raise out_ready for 2 cycles: 0xAAAA0001 then 0xAAAA0002 appear in order, and occupancy returns to 0.
- Flush with the stage in SKID (2 entries) and CLEAR_ON_FLUSH=1, flush pulsed for 1 cycle. Required: next cycle out_valid=0, occupancy=0, data_out=RESET_VAL (0x00000000).
- Stall for 3 cycles while FULL with 0xDEADBEEF and out_ready=1. Required: in_ready=0, data_out=0xDEADBEEF stable, no transfer. On release, a transfer occurs on the first cycle.
- Asynchronous reset asserted mid-cycle with occupancy=2. Required: out_valid=0 immediately (before the next clk edge) and data_out=RESET_VAL.
- With PIPE_STAGE_PERF_EN and CNT_W=4: hold out_ready=0 for 20 cycles with a valid payload. Required: bp_cnt saturates at 0xF. Then one flush: flush_cnt=1.
